// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding the HI/LO registers.
// One radix-2 step per cycle over WIDTH cycles, then a sign-fix cycle.
// Operands are reduced to magnitudes at start and the result sign is restored in FIX.

module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     rs_q;     // raw dividend, returned in HI on divide by zero
    logic                 is_mul_q;
    logic                 neg_q;    // product / quotient negative
    logic                 rneg_q;   // remainder negative (dividend sign)
    logic                 div0_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 is_mul_op;
    logic                 is_div_op;
    logic                 is_signed_op;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Operation decode and operand magnitudes for the start edge.
    always_comb begin
        is_mul_op    = (op == OpMult) || (op == OpMultu);
        is_div_op    = (op == OpDiv) || (op == OpDivu);
        is_signed_op = (op == OpMult) || (op == OpDiv);
        a_neg        = is_signed_op & rs[WIDTH-1];
        b_neg        = is_signed_op & rt[WIDTH-1];
        a_mag        = a_neg ? (~rs + 1'b1) : rs;
        b_mag        = b_neg ? (~rt + 1'b1) : rt;
    end

    // One shift-add and one restoring shift-subtract step, plus the final sign fix.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        // Borrow out means the divisor did not fit: keep the shifted remainder.
        div_next  = div_diff[WIDTH]
                  ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix   = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix   = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            rs_q     <= '0;
            is_mul_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (is_mul_op || is_div_op) begin
                            state_q  <= StCalc;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            acc_q    <= {{WIDTH{1'b0}}, (is_mul_op ? b_mag : a_mag)};
                            opnd_q   <= is_mul_op ? a_mag : b_mag;
                            rs_q     <= rs;
                            is_mul_q <= is_mul_op;
                            neg_q    <= a_neg ^ b_neg;
                            rneg_q   <= a_neg;
                            div0_q   <= is_div_op && (rt == '0);
                        end else if (op == OpMthi) begin
                            hi_q <= rs;
                        end else if (op == OpMtlo) begin
                            lo_q <= rs;
                        end
                    end
                end
                StCalc: begin
                    acc_q <= is_mul_q ? mul_next : div_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    if (is_mul_q) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (div0_q) begin
                        hi_q <= rs_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: a table of MULT/DIV vectors with hand-computed
// results, plus sequences for reset, moves, start-while-busy and mid-op reset.

module tb_mdu_iter;

    localparam int unsigned WIDTH = 32;
    localparam int          LAT   = 33;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_vec;
    int n_bad;

    mdu_iter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Issue one MULT/DIV and wait for done; reports busy length and done pulse width.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles, output int done_cycles);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0; op = 3'd6; rs = '1; rt = '1;
        busy_cycles = 0;
        while (busy && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        done_cycles = 0;
        while (done && done_cycles < 5) begin
            done_cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int bc;
        int dc;
        int i;
        int ndone;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;

        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd6;
        rs    = '0;
        rt    = '0;

        vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{3'd1, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1};
        vecs[2]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{3'd3, 32'h00000055, 32'h00000000, 32'h00000055, 32'hFFFFFFFF};
        vecs[6]  = '{3'd2, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
        vecs[7]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[9]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[10] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
        vecs[12] = '{3'd2, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2};
        vecs[13] = '{3'd0, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000};

        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);

        // MTHI / MTLO / no-op.
        start = 1'b1; op = 3'd4; rs = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        check("mthi hi", hi, 32'h12345678);
        check("mthi busy", {31'b0, busy}, 32'h0);
        start = 1'b1; op = 3'd5; rs = 32'hCAFEF00D;
        @(negedge clk);
        start = 1'b0;
        check("mtlo lo", lo, 32'hCAFEF00D);
        check("mtlo hi kept", hi, 32'h12345678);
        start = 1'b1; op = 3'd7; rs = 32'hDEADBEEF; rt = 32'h1;
        @(negedge clk);
        start = 1'b0;
        check("nop hi", hi, 32'h12345678);
        check("nop lo", lo, 32'hCAFEF00D);
        check("nop busy", {31'b0, busy}, 32'h0);

        // Table of multiply/divide vectors.
        for (int k = 0; k < 14; k++) begin
            run_op(vecs[k].op, vecs[k].rs, vecs[k].rt, bc, dc);
            check($sformatf("vec%0d busy cycles", k), bc, LAT);
            check($sformatf("vec%0d done width", k), dc, 1);
            check($sformatf("vec%0d hi", k), hi, vecs[k].exp_hi);
            check($sformatf("vec%0d lo", k), lo, vecs[k].exp_lo);
        end

        // Start during busy is ignored; new start in the done cycle is accepted.
        hold_hi = hi;
        hold_lo = lo;
        @(negedge clk);
        start = 1'b1; op = 3'd1; rs = 32'd6; rt = 32'd7;
        @(negedge clk);
        start = 1'b0;
        i = 1;
        ndone = 0;
        while (!done && i < 100) begin
            if (i == 10) begin
                start = 1'b1; op = 3'd3; rs = 32'd9; rt = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (busy && i == 20) begin
                check("hi held while busy", hi, hold_hi);
                check("lo held while busy", lo, hold_lo);
            end
            @(negedge clk);
            i++;
        end
        check("busy-start latency", i, LAT + 1);
        check("busy-start hi", hi, 32'h0);
        check("busy-start lo", lo, 32'd42);
        check("busy low in done cycle", {31'b0, busy}, 32'h0);
        // Done cycle: issue MULTU 3*4.
        start = 1'b1; op = 3'd1; rs = 32'd3; rt = 32'd4;
        @(negedge clk);
        start = 1'b0;
        check("done-cycle start busy", {31'b0, busy}, 32'h1);
        check("done-cycle start done cleared", {31'b0, done}, 32'h0);
        i = 0;
        while (!done && i < 100) begin
            if (done) ndone++;
            @(negedge clk);
            i++;
        end
        check("extra done from ignored start", ndone, 0);
        check("done-cycle op lo", lo, 32'd12);
        check("done-cycle op hi", hi, 32'd0);

        // Mid-operation reset discards the result; start alongside rst is ignored.
        @(negedge clk);
        start = 1'b1; op = 3'd3; rs = 32'd100; rt = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 3'd4; rs = 32'h00000ABC;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("midrst busy", {31'b0, busy}, 32'h0);
        check("midrst hi", hi, 32'h0);
        check("midrst lo", lo, 32'h0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("midrst no done/busy after", ndone, 0);
        check("midrst lo stays", lo, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
